load_store_unit: RTL and testbench

Data-memory access stage directly downstream of the instruction control decoder. It consumes the decoder's `memToReg`/`memWrite`/`aluOP` qualifiers together with the ALU-computed effective address and the rs2 store data. It drives a request/grant/rvalid data-memory port with byte enables, and returns sign- or zero-extended load data to write-back. A multi-cycle FSM stalls the core via `req_ready` while an access is in flight.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store definitions: decoder aluOP codes, LSU state encoding,
// byte-enable constants and the access-fault classifier.
package lsu_pkg;

  localparam logic [5:0] OpLb  = 6'd0;
  localparam logic [5:0] OpLh  = 6'd1;
  localparam logic [5:0] OpLw  = 6'd2;
  localparam logic [5:0] OpLd  = 6'd3;
  localparam logic [5:0] OpLbu = 6'd4;
  localparam logic [5:0] OpSb  = 6'd15;
  localparam logic [5:0] OpSh  = 6'd16;
  localparam logic [5:0] OpSw  = 6'd17;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} lsu_state_e;

  localparam logic [3:0] BeNone   = 4'b0000;
  localparam logic [3:0] BeByte0  = 4'b0001;
  localparam logic [3:0] BeHalfLo = 4'b0011;
  localparam logic [3:0] BeHalfHi = 4'b1100;
  localparam logic [3:0] BeWord   = 4'b1111;

  // LD is not supported on this 32-bit port, so it falls into the default fault arm.
  function automatic logic is_fault(input logic is_load, input logic is_store,
                                    input logic [5:0] op, input logic [1:0] addr_lo);
    logic f;
    f = 1'b0;
    if (is_load && is_store) begin
      f = 1'b1;
    end else if (is_load) begin
      case (op)
        OpLb, OpLbu: f = 1'b0;
        OpLh:        f = addr_lo[0];
        OpLw:        f = (addr_lo != 2'b00);
        default:     f = 1'b1;
      endcase
    end else if (is_store) begin
      case (op)
        OpSb:    f = 1'b0;
        OpSh:    f = addr_lo[0];
        OpSw:    f = (addr_lo != 2'b00);
        default: f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store replication / byte enables and
// load lane selection with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    be        = BeNone;
    wdata     = '0;
    load_data = '0;
    lane_byte = rdata[{addr_lo, 3'b000} +: 8];
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OpSb: begin
        be    = BeByte0 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      OpSh: begin
        be    = addr_lo[1] ? BeHalfHi : BeHalfLo;
        wdata = {2{store_data[15:0]}};
      end
      OpSw: begin
        be    = BeWord;
        wdata = store_data;
      end
      OpLb:    load_data = {{24{lane_byte[7]}}, lane_byte};
      OpLbu:   load_data = {24'b0, lane_byte};
      OpLh:    load_data = {{16{lane_half[15]}}, lane_half};
      OpLw:    load_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts one load/store at a time, drives a
// req/gnt/rvalid memory port and returns extended load data or a fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic [5:0]        alu_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              resp_valid,
  output logic              resp_fault,
  output logic [31:0]       load_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_fault_q, resp_fault_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;

  logic [5:0]  align_op;
  logic [1:0]  align_addr_lo;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_load;

  // One aligner serves both phases: live inputs while accepting, latched op afterwards.
  assign align_op      = (state_q == StIdle) ? alu_op : op_q;
  assign align_addr_lo = (state_q == StIdle) ? addr[1:0] : addr_lo_q;

  lsu_lane_align u_align (
    .op         (align_op),
    .addr_lo    (align_addr_lo),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (align_be),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_lo_d    = addr_lo_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_fault_d = resp_fault_q;
    load_data_d  = load_data_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && (mem_to_reg || mem_write)) begin
          op_d        = alu_op;
          addr_lo_d   = addr[1:0];
          req_ready_d = 1'b0;
          if (is_fault(mem_to_reg, mem_write, alu_op, addr[1:0])) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d      = StReq;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write;
            dmem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            dmem_be_d    = mem_write ? align_be : BeNone;
            dmem_wdata_d = mem_write ? align_wdata : '0;
          end
        end
      end
      StReq: begin
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (dmem_rvalid) begin
          load_data_d  = align_load;
          state_d      = StResp;
          resp_valid_d = 1'b1;
        end
      end
      StResp: begin
        state_d      = StIdle;
        req_ready_d  = 1'b1;
        resp_fault_d = 1'b0;
        load_data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      addr_lo_q    <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      load_data_q  <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_lo_q    <= addr_lo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      load_data_q  <= load_data_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign load_data  = load_data_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small memory responder drives
// gnt/rvalid, and expected responses are queued and popped on resp_valid.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_to_reg;
  logic        mem_write;
  logic [5:0]  alu_op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic        resp_fault;
  logic [31:0] load_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  typedef struct {
    logic        fault;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .mem_to_reg  (mem_to_reg),
    .mem_write   (mem_write),
    .alu_op      (alu_op),
    .addr        (addr),
    .store_data  (store_data),
    .resp_valid  (resp_valid),
    .resp_fault  (resp_fault),
    .load_data   (load_data),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // req_cyc: cycles dmem_req is high (gnt on the last); rv_cyc: WAIT cycles (rvalid on the last).
  task automatic access(input string tag, input logic ld, input logic st, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] sd, input int req_cyc,
                        input int rv_cyc, input logic [31:0] rd, input logic exp_fault,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    exp_t e;
    exp_t x;
    int   req_seen;
    int   wait_seen;
    bit   in_wait;
    bit   done;
    req_seen  = 0;
    wait_seen = 0;
    in_wait   = 1'b0;
    done      = 1'b0;
    e.fault = exp_fault;
    e.data  = exp_data;
    e.lat   = exp_fault ? 1 : (st ? 1 + req_cyc : 1 + req_cyc + rv_cyc);
    sb_q.push_back(e);
    @(negedge clk);
    chk({tag, " ready before"}, req_ready, 1);
    req_valid  = 1'b1;
    mem_to_reg = ld;
    mem_write  = st;
    alu_op     = op;
    addr       = a;
    store_data = sd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    addr       = ~a;
    store_data = ~sd;
    alu_op     = 6'h3f;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = ~rd;
      if (resp_valid) begin
        chk({tag, " sb nonempty"}, sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          x = sb_q.pop_front();
          chk({tag, " latency"}, k, x.lat);
          chk({tag, " fault"}, resp_fault, x.fault);
          chk({tag, " load_data"}, load_data, x.data);
        end
        chk({tag, " req cycles"}, req_seen, exp_fault ? 0 : req_cyc);
        chk({tag, " ready in resp"}, req_ready, 0);
        done = 1'b1;
      end else begin
        chk({tag, " ready busy"}, req_ready, 0);
        if (dmem_req) begin
          req_seen++;
          chk({tag, " we"}, dmem_we, st);
          chk({tag, " dmem_addr"}, dmem_addr, exp_addr);
          chk({tag, " be"}, dmem_be, exp_be);
          chk({tag, " wdata"}, dmem_wdata, exp_wdata);
          if (req_seen == req_cyc) begin
            dmem_gnt = 1'b1;
            in_wait  = !st;
          end
        end else if (in_wait) begin
          wait_seen++;
          if (wait_seen == rv_cyc) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rd;
          end
        end
      end
    end
    chk({tag, " resp seen"}, done, 1);
    @(negedge clk);
    chk({tag, " single pulse"}, resp_valid, 0);
    chk({tag, " ready after"}, req_ready, 1);
    chk({tag, " fault cleared"}, resp_fault, 0);
    chk({tag, " data cleared"}, load_data, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, req_ready, 1);
    chk({tag, " resp_valid"}, resp_valid, 0);
    chk({tag, " resp_fault"}, resp_fault, 0);
    chk({tag, " load_data"}, load_data, 0);
    chk({tag, " dmem_req"}, dmem_req, 0);
    chk({tag, " dmem_we"}, dmem_we, 0);
    chk({tag, " dmem_addr"}, dmem_addr, 0);
    chk({tag, " dmem_be"}, dmem_be, 0);
    chk({tag, " dmem_wdata"}, dmem_wdata, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    mem_to_reg  = 1'b0;
    mem_write   = 1'b0;
    alu_op      = '0;
    addr        = '0;
    store_data  = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    access("sw", 0, 1, 6'd17, 32'h104, 32'hDEADBEEF, 1, 0, 0,
           0, 32'h104, 4'b1111, 32'hDEADBEEF, 0);
    access("sb", 0, 1, 6'd15, 32'h103, 32'h000000A5, 1, 0, 0,
           0, 32'h100, 4'b1000, 32'hA5A5A5A5, 0);
    access("sh", 0, 1, 6'd16, 32'h102, 32'h00001234, 1, 0, 0,
           0, 32'h100, 4'b1100, 32'h12341234, 0);
    access("lb", 1, 0, 6'd0, 32'h101, 0, 1, 1, 32'h0000F000,
           0, 32'h100, 4'b0000, 0, 32'hFFFFFFF0);
    access("lbu", 1, 0, 6'd4, 32'h101, 0, 1, 1, 32'h0000F000,
           0, 32'h100, 4'b0000, 0, 32'h000000F0);
    access("lh", 1, 0, 6'd1, 32'h102, 0, 1, 1, 32'h80000000,
           0, 32'h100, 4'b0000, 0, 32'hFFFF8000);
    access("lw mis", 1, 0, 6'd2, 32'h202, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    access("ld", 1, 0, 6'd3, 32'h200, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    access("both", 1, 1, 6'd2, 32'h200, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    access("st class", 0, 1, 6'd2, 32'h200, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    access("lw slow", 1, 0, 6'd2, 32'h200, 0, 3, 3, 32'h13579BDF,
           0, 32'h200, 4'b0000, 0, 32'h13579BDF);

    // Neither qualifier set: request must be dropped.
    @(negedge clk);
    req_valid  = 1'b1;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_op     = 6'd2;
    addr       = 32'h400;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("ignore ready", req_ready, 1);
      chk("ignore req", dmem_req, 0);
      chk("ignore resp", resp_valid, 0);
    end

    // Reset while waiting for read data, then a stale rvalid.
    @(negedge clk);
    req_valid  = 1'b1;
    mem_to_reg = 1'b1;
    mem_write  = 1'b0;
    alu_op     = 6'd2;
    addr       = 32'h300;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst req up", dmem_req, 1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rst in wait", dmem_req, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h55AA55AA;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("late rvalid resp", resp_valid, 0);
    @(negedge clk);
    chk("late rvalid resp2", resp_valid, 0);
    chk("late rvalid ready", req_ready, 1);

    access("post sw", 0, 1, 6'd17, 32'h308, 32'h0BADF00D, 2, 0, 0,
           0, 32'h308, 4'b1111, 32'h0BADF00D, 0);
    access("post lbu", 1, 0, 6'd4, 32'h30A, 0, 1, 2, 32'h00C30000,
           0, 32'h308, 4'b0000, 0, 32'h000000C3);

    chk("sb drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
